// File: rtl/jk_bank_pkg.sv
// Shared opcode and FSM encodings for the JK bank controller.
package jk_bank_pkg;

  localparam logic [2:0] OP_HOLD       = 3'd0;
  localparam logic [2:0] OP_CLEAR      = 3'd1;
  localparam logic [2:0] OP_LOAD       = 3'd2;
  localparam logic [2:0] OP_TOGGLE     = 3'd3;
  localparam logic [2:0] OP_COUNT_UP   = 3'd4;
  localparam logic [2:0] OP_COUNT_DOWN = 3'd5;
  localparam logic [2:0] OP_RSVD_LO    = 3'd6;
  localparam logic [2:0] OP_RSVD_HI    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_COUNT = 2'd2
  } state_t;

  function automatic logic is_count_op(input logic [2:0] op);
    return (op == OP_COUNT_UP) || (op == OP_COUNT_DOWN);
  endfunction

  function automatic logic is_reserved(input logic [2:0] op);
    return (op == OP_RSVD_LO) || (op == OP_RSVD_HI);
  endfunction

endpackage

// File: rtl/jk_bank_ctrl_jk_cell.sv
// Single JK flip-flop with synchronous active-low reset to 0.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qn = ~q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command-driven sequencer for a bank of JK cells: hold/clear/load/toggle/count.
module jk_bank_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
);
  import jk_bank_pkg::*;

  state_t           state, state_nx;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] j, k, q_i, qn_i;
  logic             accept, last_step, run;

  assign accept    = cmd_valid && (state == ST_IDLE);
  assign last_step = (cnt_r == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_count_op(cmd_op) && (cmd_len != '0)) state_nx = ST_COUNT;
          else                                         state_nx = ST_EXEC;
        end
      end
      ST_EXEC:  state_nx = ST_IDLE;
      ST_COUNT: if (last_step) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_r   <= OP_HOLD;
      data_r <= '0;
      cnt_r  <= '0;
      done   <= 1'b0;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
      if (accept) begin
        op_r   <= cmd_op;
        data_r <= cmd_data;
        cnt_r  <= cmd_len;
      end
      case (state)
        ST_EXEC: begin
          done <= 1'b1;
          err  <= is_reserved(op_r);
        end
        ST_COUNT: begin
          cnt_r <= cnt_r - CNT_W'(1);
          done  <= last_step;
          // Wrap is judged on the pre-update value that this edge rolls over.
          wrap  <= (op_r == OP_COUNT_UP) ? (&q_i) : ~(|q_i);
        end
        default: ;
      endcase
    end
  end

  // Zero-length count ops only ever reach EXEC, where they fall to the hold default.
  always_comb begin
    j   = '0;
    k   = '0;
    run = 1'b1;
    case (state)
      ST_EXEC: begin
        case (op_r)
          OP_CLEAR:  k = '1;
          OP_LOAD:   begin j = data_r; k = ~data_r; end
          OP_TOGGLE: begin j = data_r; k = data_r;  end
          default:   ;
        endcase
      end
      ST_COUNT: begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          j[i] = run;
          k[i] = run;
          run  = run & ((op_r == OP_COUNT_UP) ? q_i[i] : qn_i[i]);
        end
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j[g]),
      .k   (k[g]),
      .q   (q_i[g]),
      .qn  (qn_i[g])
    );
  end

  assign q         = q_i;
  assign qn        = qn_i;
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl: reset, single-cycle ops, counting with wrap, abort, reserved op.
module tb_jk_bank_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_len;
  logic [WIDTH-1:0] q, qn;
  logic             busy, done, wrap, err;

  int n_assert = 0;
  int n_fail   = 0;

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .q         (q),
    .qn        (qn),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command for exactly one edge (it is accepted there when idle).
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] data, input logic [CNT_W-1:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    cyc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_len = '0;
    cyc(); cyc();
    chk("rst_q", q, 4'h0);
    chk("rst_qn", qn, 4'hF);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    cyc();

    // LOAD 1010 then TOGGLE 0110
    send(3'd2, 4'b1010, 8'd0);
    chk("load_ready_exec", cmd_ready, 0);
    chk("load_busy_exec", busy, 1);
    chk("load_done_exec", done, 0);
    cyc();
    chk("load_q", q, 4'b1010);
    chk("load_qn", qn, 4'b0101);
    chk("load_done", done, 1);
    chk("load_ready", cmd_ready, 1);
    send(3'd3, 4'b0110, 8'd0);
    chk("tog_ready_exec", cmd_ready, 0);
    chk("tog_q_exec", q, 4'b1010);
    chk("tog_done_exec", done, 0);
    cyc();
    chk("tog_q", q, 4'b1100);
    chk("tog_done", done, 1);
    chk("tog_err", err, 0);

    // COUNT_UP 5 from 1101
    send(3'd2, 4'b1101, 8'd0);
    cyc();
    chk("pre_up_q", q, 4'b1101);
    send(3'd4, 4'b0000, 8'd5);
    chk("up_busy0", busy, 1);
    chk("up_q0", q, 4'b1101);
    cyc(); chk("up_q1", q, 4'b1110); chk("up_wrap1", wrap, 0); chk("up_busy1", busy, 1);
    cyc(); chk("up_q2", q, 4'b1111); chk("up_wrap2", wrap, 0); chk("up_done2", done, 0);
    cyc(); chk("up_q3", q, 4'b0000); chk("up_wrap3", wrap, 1); chk("up_busy3", busy, 1);
    cyc(); chk("up_q4", q, 4'b0001); chk("up_wrap4", wrap, 0); chk("up_busy4", busy, 1);
    cyc(); chk("up_q5", q, 4'b0010); chk("up_done5", done, 1); chk("up_busy5", busy, 0);
    chk("up_wrap5", wrap, 0);
    cyc(); chk("up_done_after", done, 0); chk("up_q_hold", q, 4'b0010);

    // COUNT_DOWN 3 from 0001, then zero-length COUNT_UP
    send(3'd2, 4'b0001, 8'd0);
    cyc();
    send(3'd5, 4'b0000, 8'd3);
    cyc(); chk("dn_q1", q, 4'b0000); chk("dn_wrap1", wrap, 0);
    cyc(); chk("dn_q2", q, 4'b1111); chk("dn_wrap2", wrap, 1); chk("dn_qn2", qn, 4'b0000);
    cyc(); chk("dn_q3", q, 4'b1110); chk("dn_wrap3", wrap, 0); chk("dn_done3", done, 1);
    send(3'd4, 4'b0000, 8'd0);
    chk("len0_busy", busy, 1);
    chk("len0_ready", cmd_ready, 0);
    cyc();
    chk("len0_q", q, 4'b1110);
    chk("len0_done", done, 1);
    chk("len0_wrap", wrap, 0);
    chk("len0_busy_after", busy, 0);

    // CLEAR held valid during COUNT_UP 4, reset after 2 steps
    send(3'd4, 4'b0000, 8'd4);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = '0; cmd_len = '0;
    chk("abort_ready0", cmd_ready, 0);
    cyc(); chk("abort_q1", q, 4'b1111); chk("abort_ready1", cmd_ready, 0);
    cyc(); chk("abort_q2", q, 4'b0000); chk("abort_wrap2", wrap, 1);
    rst = 1'b0;
    cyc();
    chk("abort_rst_q", q, 4'b0000);
    chk("abort_rst_busy", busy, 0);
    chk("abort_rst_done", done, 0);
    chk("abort_rst_wrap", wrap, 0);
    chk("abort_rst_ready", cmd_ready, 1);
    rst = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    chk("clr_busy", busy, 1);
    chk("clr_done_none", done, 0);
    cyc();
    chk("clr_q", q, 4'b0000);
    chk("clr_done", done, 1);

    // Reserved opcode leaves q alone and flags err with done
    send(3'd2, 4'b0101, 8'd0);
    cyc();
    send(3'd7, 4'b1111, 8'd9);
    chk("rsv_busy", busy, 1);
    cyc();
    chk("rsv_q", q, 4'b0101);
    chk("rsv_done", done, 1);
    chk("rsv_err", err, 1);
    chk("rsv_busy_after", busy, 0);
    cyc();
    chk("rsv_err_clear", err, 0);
    chk("rsv_done_clear", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
